// File: rtl/trdb_pkg.sv
// Shared trace-encoder packet types for the packet scheduler.
// Packet formats, sync subformats, qualification status and queued request bundle.
package trdb_pkg;

  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'h0,
    F_DIFF_DELTA = 2'h1,
    F_ADDR_ONLY  = 2'h2,
    F_SYNC       = 2'h3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'h0,
    SF_TRAP    = 2'h1,
    SF_CONTEXT = 2'h2,
    SF_SUPPORT = 2'h3
  } trdb_f_sync_subformat_e;

  typedef enum logic [1:0] {
    NO_CHANGE  = 2'h0,
    ENDED_REP  = 2'h1,
    TRACE_LOST = 2'h2,
    ENDED_NTR  = 2'h3
  } qual_status_e;

  typedef struct packed {
    trdb_format_e           format;
    trdb_f_sync_subformat_e subformat;
    logic                   thaddr;
    logic                   lc_tc_mux;
    qual_status_e           qual_status;
  } trdb_pkt_req_s;

  function automatic logic is_sync_support(trdb_pkt_req_s r);
    return (r.format == F_SYNC) && (r.subformat == SF_SUPPORT);
  endfunction

endpackage

// File: rtl/trdb_pkt_fifo.sv
// Request queue for the packet scheduler; caller gates push/pop.
// Head reads as zero when empty so the payload idles at its reset value.
module trdb_pkt_fifo
  import trdb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  trdb_pkt_req_s            data_i,
  input  logic                     pop_i,
  output trdb_pkt_req_s            data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q;
  trdb_pkt_req_s mem_q [DEPTH];

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      if (push_i && !pop_i)      level_q <= level_q + 1'b1;
      else if (pop_i && !push_i) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/trdb_packet_sched.sv
// Packet request scheduler: FIFO queue, overflow tracking, resync timer.
// Resync timer is built only when TRDB_RESYNC_EN is defined.
module trdb_packet_sched
  import trdb_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESYNC_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  trdb_format_e           format_i,
  input  trdb_f_sync_subformat_e subformat_i,
  input  logic                   thaddr_i,
  input  logic                   lc_tc_mux_i,
  input  qual_status_e           qual_status_i,
  input  logic                   flush_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output trdb_format_e           format_o,
  output trdb_f_sync_subformat_e subformat_o,
  output logic                   thaddr_o,
  output logic                   lc_tc_mux_o,
  output qual_status_e           qual_status_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   lost_o,
  output logic                   lost_sticky_o,
  input  logic                   resync_tick_i,
  input  logic                   resync_rst_i,
  input  logic [RESYNC_W-1:0]    resync_max_i,
  output logic                   gt_max_resync_o,
  output logic                   et_max_resync_o
);

  trdb_pkt_req_s req_in, head;
  logic full, empty, push_en, pop_en, drop;
  logic lost_q, sticky_q;

  assign req_in = '{format:      format_i,
                    subformat:   subformat_i,
                    thaddr:      thaddr_i,
                    lc_tc_mux:   lc_tc_mux_i,
                    qual_status: qual_status_i};

  assign valid_o = !empty;
  assign pop_en  = valid_o && ready_i;
  assign push_en = valid_i && !flush_i && (!full || pop_en);
  assign drop    = valid_i && !flush_i && full && !pop_en;

  trdb_pkt_fifo #(
    .DEPTH (DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push_en),
    .data_i  (req_in),
    .pop_i   (pop_en),
    .data_o  (head),
    .level_o (level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  assign format_o      = head.format;
  assign subformat_o   = head.subformat;
  assign thaddr_o      = head.thaddr;
  assign lc_tc_mux_o   = head.lc_tc_mux;
  assign qual_status_o = head.qual_status;

  // A new loss outranks a same-cycle support-packet clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lost_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      lost_q <= drop;
      if (drop)
        sticky_q <= 1'b1;
      else if (pop_en && is_sync_support(head))
        sticky_q <= 1'b0;
    end
  end

  assign lost_o        = lost_q;
  assign lost_sticky_o = sticky_q;

`ifdef TRDB_RESYNC_EN
  logic [RESYNC_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else if (resync_rst_i)
      cnt_q <= '0;
    else if (resync_tick_i && (cnt_q != '1))
      cnt_q <= cnt_q + 1'b1;
  end

  assign gt_max_resync_o = (cnt_q >= resync_max_i);
  assign et_max_resync_o = (resync_max_i != '0) &&
                           (cnt_q == resync_max_i - RESYNC_W'(1));
`else
  logic unused_resync;
  assign unused_resync   = ^{resync_tick_i, resync_rst_i, resync_max_i};
  assign gt_max_resync_o = 1'b0;
  assign et_max_resync_o = 1'b0;
`endif

endmodule

// File: tb/tb_trdb_packet_sched.sv
// Directed self-checking bench for trdb_packet_sched (DEPTH=4).
// Payloads are packed {format,subformat,thaddr,lc_tc_mux,qual} bytes.
module tb_trdb_packet_sched;
  import trdb_pkg::*;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   valid_i;
  trdb_format_e           format_i;
  trdb_f_sync_subformat_e subformat_i;
  logic                   thaddr_i;
  logic                   lc_tc_mux_i;
  qual_status_e           qual_status_i;
  logic                   flush_i;
  logic                   valid_o;
  logic                   ready_i;
  trdb_format_e           format_o;
  trdb_f_sync_subformat_e subformat_o;
  logic                   thaddr_o;
  logic                   lc_tc_mux_o;
  qual_status_e           qual_status_o;
  logic [2:0]             level_o;
  logic                   lost_o;
  logic                   lost_sticky_o;
  logic                   resync_tick_i;
  logic                   resync_rst_i;
  logic [15:0]            resync_max_i;
  logic                   gt_max_resync_o;
  logic                   et_max_resync_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [7:0] PA = 8'hF0;
  localparam logic [7:0] PB = 8'h89;
  localparam logic [7:0] PC = 8'h56;
  localparam logic [7:0] PD = 8'h2F;
  localparam logic [7:0] PX = 8'hFD;
  localparam logic [7:0] PE = 8'h93;
  localparam logic [7:0] PF = 8'h4A;

  trdb_packet_sched #(
    .DEPTH    (4),
    .RESYNC_W (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .valid_i         (valid_i),
    .format_i        (format_i),
    .subformat_i     (subformat_i),
    .thaddr_i        (thaddr_i),
    .lc_tc_mux_i     (lc_tc_mux_i),
    .qual_status_i   (qual_status_i),
    .flush_i         (flush_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .format_o        (format_o),
    .subformat_o     (subformat_o),
    .thaddr_o        (thaddr_o),
    .lc_tc_mux_o     (lc_tc_mux_o),
    .qual_status_o   (qual_status_o),
    .level_o         (level_o),
    .lost_o          (lost_o),
    .lost_sticky_o   (lost_sticky_o),
    .resync_tick_i   (resync_tick_i),
    .resync_rst_i    (resync_rst_i),
    .resync_max_i    (resync_max_i),
    .gt_max_resync_o (gt_max_resync_o),
    .et_max_resync_o (et_max_resync_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] head();
    return {format_o, subformat_o, thaddr_o, lc_tc_mux_o, qual_status_o};
  endfunction

  task automatic drive(input logic v, input logic [7:0] p);
    valid_i       = v;
    format_i      = trdb_format_e'(p[7:6]);
    subformat_i   = trdb_f_sync_subformat_e'(p[5:4]);
    thaddr_i      = p[3];
    lc_tc_mux_i   = p[2];
    qual_status_i = qual_status_e'(p[1:0]);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni        = 1'b0;
    drive(1'b0, 8'h00);
    flush_i       = 1'b0;
    ready_i       = 1'b0;
    resync_tick_i = 1'b0;
    resync_rst_i  = 1'b0;
    resync_max_i  = 16'd5;
    #2;
    chk("rst_valid", valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_lost", lost_o, 0);
    chk("rst_sticky", lost_sticky_o, 0);
    chk("rst_head", head(), 0);
    chk("rst_gt", gt_max_resync_o, 0);
    chk("rst_et", et_max_resync_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // one-cycle latency, no bypass
    drive(1'b1, PC);
    ready_i = 1'b1;
    #1;
    chk("lat_nobypass", valid_o, 0);
    tick();
    drive(1'b0, 8'h00);
    chk("lat_valid1", valid_o, 1);
    chk("lat_level1", level_o, 1);
    chk("lat_head", head(), PC);
    tick();
    chk("lat_valid0", valid_o, 0);
    chk("lat_level0", level_o, 0);

    // fill, overflow, sticky
    ready_i = 1'b0;
    drive(1'b1, PA); tick();
    drive(1'b1, PB); tick();
    drive(1'b1, PC); tick();
    drive(1'b1, PD); tick();
    chk("fill_level", level_o, 4);
    chk("fill_nolost", lost_o, 0);
    chk("fill_head", head(), PA);
    drive(1'b1, PX); tick();
    chk("ovf_lost", lost_o, 1);
    chk("ovf_sticky", lost_sticky_o, 1);
    chk("ovf_level", level_o, 4);
    drive(1'b0, 8'h00); tick();
    chk("ovf_lost_pulse", lost_o, 0);
    chk("ovf_sticky_hold", lost_sticky_o, 1);
    chk("stall_head", head(), PA);
    ready_i = 1'b1; tick();
    chk("clr_sticky", lost_sticky_o, 0);
    chk("clr_level", level_o, 3);
    chk("clr_head", head(), PB);

    // full with simultaneous push and pop
    ready_i = 1'b0;
    drive(1'b1, PE); tick();
    chk("full2_level", level_o, 4);
    ready_i = 1'b1;
    drive(1'b1, PF); tick();
    chk("pp_level", level_o, 4);
    chk("pp_lost", lost_o, 0);
    chk("pp_head1", head(), PC);
    drive(1'b0, 8'h00); tick();
    chk("pp_head2", head(), PD);
    tick();
    chk("pp_head3", head(), PE);
    tick();
    chk("pp_head4", head(), PF);
    tick();
    chk("pp_empty", level_o, 0);
    chk("pp_valid0", valid_o, 0);

    // flush at level 3 with a concurrent push
    ready_i = 1'b0;
    drive(1'b1, PA); tick();
    drive(1'b1, PB); tick();
    drive(1'b1, PC); tick();
    chk("fl_level3", level_o, 3);
    flush_i = 1'b1;
    drive(1'b1, PD); tick();
    flush_i = 1'b0;
    drive(1'b0, 8'h00);
    chk("fl_level", level_o, 0);
    chk("fl_valid", valid_o, 0);
    chk("fl_lost", lost_o, 0);
    tick();
    chk("fl_stays", level_o, 0);

    // resync timer
    resync_rst_i = 1'b1; tick();
    resync_rst_i = 1'b0;
`ifdef TRDB_RESYNC_EN
    chk("rs_gt0", gt_max_resync_o, 0);
    resync_tick_i = 1'b1;
    repeat (4) tick();
    chk("rs_et4", et_max_resync_o, 1);
    chk("rs_gt4", gt_max_resync_o, 0);
    tick();
    chk("rs_gt5", gt_max_resync_o, 1);
    chk("rs_et5", et_max_resync_o, 0);
    resync_rst_i = 1'b1; tick();
    resync_rst_i  = 1'b0;
    resync_tick_i = 1'b0;
    chk("rs_clr_gt", gt_max_resync_o, 0);
    chk("rs_clr_et", et_max_resync_o, 0);
    resync_max_i = 16'd0;
    #1;
    chk("rs_max0_gt", gt_max_resync_o, 1);
    chk("rs_max0_et", et_max_resync_o, 0);
    resync_max_i = 16'd5;
`else
    resync_tick_i = 1'b1;
    repeat (6) tick();
    resync_tick_i = 1'b0;
    chk("rs_off_gt", gt_max_resync_o, 0);
    chk("rs_off_et", et_max_resync_o, 0);
`endif

    // asynchronous reset mid-stream
    drive(1'b1, PB); tick();
    drive(1'b1, PD); tick();
    drive(1'b0, 8'h00);
    chk("ar_level2", level_o, 2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_valid", valid_o, 0);
    chk("ar_level", level_o, 0);
    chk("ar_head", head(), 0);
    chk("ar_lost", lost_o, 0);
    chk("ar_sticky", lost_sticky_o, 0);
    chk("ar_gt", gt_max_resync_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("ar_after", valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
